// File: rtl/uart_rx_voter.sv
// uart_rx_voter: oversampling 8N1 UART receiver with a 2-FF input synchronizer,
// 3-sample majority voting per bit, false-start rejection and framing-error
// reporting with break handling.
// Optional build macro UART_RX_PARITY_EN: adds one even-parity bit between the
// data bits and the stop bit, plus a parity_err pulse output.
module uart_rx_voter #(
    parameter int CLK_PER_BIT = 16,
    parameter int CNT_W       = $clog2(CLK_PER_BIT)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_serial_line,
    output logic [7:0] rx_data,
    output logic       rx_ready,
    output logic       frame_err,
`ifdef UART_RX_PARITY_EN
    output logic       parity_err,
`endif
    output logic       busy
);

    localparam int M = CLK_PER_BIT / 2;

    // Counter values at which the three votes are taken and the bit period ends.
    localparam logic [CNT_W-1:0] CNT_S0   = CNT_W'(M - 1);
    localparam logic [CNT_W-1:0] CNT_S1   = CNT_W'(M);
    localparam logic [CNT_W-1:0] CNT_DEC  = CNT_W'(M + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        BRK
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       sync_q, sync_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [1:0]       samp_q, samp_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             rx_ready_q, rx_ready_d;
    logic             frame_err_q, frame_err_d;
    logic             busy_q, busy_d;
`ifdef UART_RX_PARITY_EN
    logic             par_q, par_d;
    logic             parity_err_q, parity_err_d;
`endif

    logic rx_s;
    logic vote;

    // Synchronized line; the second stage is the only copy any decision uses.
    assign rx_s = sync_q[1];

    // Majority of the samples at M-1, M and the live sample at M+1.
    assign vote = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s) | (samp_q[1] & rx_s);

    // Next-state logic: synchronizer shift, bit timing, voting and frame FSM.
    always_comb begin
        state_d     = state_q;
        sync_d      = {sync_q[0], rx_serial_line};
        cnt_d       = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        bit_idx_d   = bit_idx_q;
        samp_d      = samp_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        rx_ready_d  = 1'b0;
        frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d        = par_q;
        parity_err_d = 1'b0;
`endif

        if (cnt_q == CNT_S0) samp_d[0] = rx_s;
        if (cnt_q == CNT_S1) samp_d[1] = rx_s;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rx_s) state_d = START;
            end
            START: begin
                // A start bit that votes high at mid-bit was noise.
                if (cnt_q == CNT_DEC && vote) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = DATA;
                    bit_idx_d = 3'd0;
                end
            end
            DATA: begin
                if (cnt_q == CNT_DEC) shift_d = {vote, shift_q[7:1]};
                if (cnt_q == CNT_LAST) begin
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt_q == CNT_DEC) par_d = vote;
                if (cnt_q == CNT_LAST) state_d = STOP;
            end
`endif
            STOP: begin
                // Decide at mid-stop so a back-to-back start bit is not missed.
                if (cnt_q == CNT_DEC) begin
                    cnt_d = '0;
                    if (vote) begin
                        state_d = IDLE;
`ifdef UART_RX_PARITY_EN
                        if (^{shift_q, par_q}) begin
                            parity_err_d = 1'b1;
                        end else begin
                            rx_data_d  = shift_q;
                            rx_ready_d = 1'b1;
                        end
`else
                        rx_data_d  = shift_q;
                        rx_ready_d = 1'b1;
`endif
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = BRK;
                    end
                end
            end
            BRK: begin
                // A line held low is a break, not a new start bit.
                cnt_d = '0;
                if (rx_s) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and registered outputs.
    // NOTE: every flop here is assigned with <= so all of them update from the
    // same pre-edge values; the data-path registers are reset too, since
    // rx_data must read 8'h00 after any reset, including one mid-frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sync_q      <= 2'b11;
            cnt_q       <= '0;
            bit_idx_q   <= 3'd0;
            samp_q      <= 2'b11;
            shift_q     <= 8'h00;
            rx_data_q   <= 8'h00;
            rx_ready_q  <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q        <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            sync_q      <= sync_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            samp_q      <= samp_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_ready_q  <= rx_ready_d;
            frame_err_q <= frame_err_d;
            busy_q      <= busy_d;
`ifdef UART_RX_PARITY_EN
            par_q        <= par_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_ready  = rx_ready_q;
    assign frame_err = frame_err_q;
    assign busy      = busy_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx_voter.sv
// Directed testbench for uart_rx_voter (CLK_PER_BIT = 16). Builds with or
// without UART_RX_PARITY_EN; the parity steps exist only in the parity build.
module tb_uart_rx_voter;

    localparam int CPB = 16;
    localparam int M   = CPB / 2;
`ifdef UART_RX_PARITY_EN
    localparam int LAT = 10 * CPB + M + 2;
`else
    localparam int LAT = 9 * CPB + M + 2;
`endif

    logic       clk;
    logic       rst_n;
    logic       line;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       frame_err;
    logic       busy;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
    logic       bad_par;
`endif

    uart_rx_voter #(.CLK_PER_BIT(CPB)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rx_serial_line (line),
        .rx_data        (rx_data),
        .rx_ready       (rx_ready),
        .frame_err      (frame_err),
`ifdef UART_RX_PARITY_EN
        .parity_err     (parity_err),
`endif
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Pulse monitor, sampled on the falling edge.
    int         cyc = 0;
    int         ready_cnt = 0;
    int         ferr_cnt = 0;
    int         perr_cnt = 0;
    int         busy_rise_cyc = 0;
    int         busy_fall_cyc = 0;
    int         ready_cyc = 0;
    int         perr_cyc = 0;
    logic       ready_busy = 1'b1;
    logic       busy_prev = 1'b0;
    logic       ready_prev = 1'b0;
    logic       both_seen = 1'b0;
    logic       double_seen = 1'b0;
    logic [7:0] data_log[$];

    always @(negedge clk) begin
        cyc        <= cyc + 1;
        busy_prev  <= busy;
        ready_prev <= rx_ready;
        if (busy && !busy_prev) busy_rise_cyc <= cyc;
        if (!busy && busy_prev) busy_fall_cyc <= cyc;
        if (rx_ready) begin
            ready_cnt  <= ready_cnt + 1;
            ready_cyc  <= cyc;
            ready_busy <= busy;
            data_log.push_back(rx_data);
        end
        if (frame_err) ferr_cnt <= ferr_cnt + 1;
        if (rx_ready && frame_err) both_seen <= 1'b1;
        if (rx_ready && ready_prev) double_seen <= 1'b1;
`ifdef UART_RX_PARITY_EN
        if (parity_err) begin
            perr_cnt <= perr_cnt + 1;
            perr_cyc <= cyc;
        end
`endif
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One bit period; optional single-clock low spike that lands on the mid-bit sample.
    task automatic drive_bit(input logic v, input bit spike);
        for (int k = 0; k < CPB; k++) begin
            line = (spike && k == M + 1) ? 1'b0 : v;
            @(negedge clk);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input int glitch_bit);
        drive_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i], i == glitch_bit);
`ifdef UART_RX_PARITY_EN
        drive_bit((^d) ^ bad_par, 1'b0);
`endif
        drive_bit(stop, 1'b0);
    endtask

    function automatic logic [7:0] log_at(input int idx);
        return (idx < data_log.size()) ? data_log[idx] : 8'hxx;
    endfunction

    int r0, f0, p0, n0;

    initial begin
        rst_n = 1'b0;
        line  = 1'b1;
`ifdef UART_RX_PARITY_EN
        bad_par = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("reset_rx_data",   32'(rx_data),   32'h00);
        check("reset_rx_ready",  32'(rx_ready),  32'h0);
        check("reset_frame_err", 32'(frame_err), 32'h0);
        check("reset_busy",      32'(busy),      32'h0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Good frame 0xA5: one pulse, fixed latency, busy drops with the pulse.
        r0 = ready_cnt;
        send_frame(8'hA5, 1'b1, -1);
        repeat (4) @(negedge clk);
        check("a5_pulses",  32'(ready_cnt - r0), 32'd1);
        check("a5_data",    32'(rx_data), 32'hA5);
        check("a5_latency", 32'(ready_cyc - busy_rise_cyc), 32'(LAT));
        check("a5_busy_at_ready", 32'(ready_busy), 32'h0);

        // False start: 3-clock low pulse.
        r0 = ready_cnt;
        f0 = ferr_cnt;
        line = 1'b0;
        repeat (3) @(negedge clk);
        line = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        check("false_no_ready", 32'(ready_cnt - r0), 32'd0);
        check("false_no_ferr",  32'(ferr_cnt - f0),  32'd0);
        check("false_busy_low", 32'(busy), 32'h0);
        check("false_busy_len_ok", 32'((busy_fall_cyc - busy_rise_cyc) <= M + 3), 32'h1);

        // Framing error on 0x3C, then a 40-bit break.
        r0 = ready_cnt;
        f0 = ferr_cnt;
        send_frame(8'h3C, 1'b0, -1);
        repeat (40 * CPB) @(negedge clk);
        check("brk_ferr_once", 32'(ferr_cnt - f0),  32'd1);
        check("brk_no_ready",  32'(ready_cnt - r0), 32'd0);
        check("brk_data_kept", 32'(rx_data), 32'hA5);
        check("brk_busy_held", 32'(busy), 32'h1);
        line = 1'b1;
        repeat (8) @(negedge clk);
        check("brk_busy_released", 32'(busy), 32'h0);
        check("brk_no_extra_ferr", 32'(ferr_cnt - f0), 32'd1);

        // Back-to-back frames, no idle gap.
        r0 = ready_cnt;
        n0 = data_log.size();
        send_frame(8'h03, 1'b1, -1);
        send_frame(8'h00, 1'b1, -1);
        repeat (8) @(negedge clk);
        check("b2b_pulses", 32'(ready_cnt - r0), 32'd2);
        check("b2b_first",  32'(log_at(n0)),     32'h03);
        check("b2b_second", 32'(log_at(n0 + 1)), 32'h00);

        // 0xFF with a one-clock low spike at mid bit 4.
        r0 = ready_cnt;
        send_frame(8'hFF, 1'b1, 4);
        repeat (4) @(negedge clk);
        check("glitch_pulses", 32'(ready_cnt - r0), 32'd1);
        check("glitch_data",   32'(rx_data), 32'hFF);

        // Reset in the middle of 0x55.
        r0 = ready_cnt;
        f0 = ferr_cnt;
        drive_bit(1'b0, 1'b0);
        drive_bit(1'b1, 1'b0);
        drive_bit(1'b0, 1'b0);
        drive_bit(1'b1, 1'b0);
        rst_n = 1'b0;
        line  = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_mid_data", 32'(rx_data), 32'h00);
        check("rst_mid_busy", 32'(busy), 32'h0);
        rst_n = 1'b1;
        repeat (12 * CPB) @(negedge clk);
        check("rst_mid_no_ready", 32'(ready_cnt - r0), 32'd0);
        check("rst_mid_no_ferr",  32'(ferr_cnt - f0),  32'd0);
        check("rst_mid_data_after", 32'(rx_data), 32'h00);

`ifdef UART_RX_PARITY_EN
        // 0x07 with wrong parity, then with correct parity.
        r0 = ready_cnt;
        p0 = perr_cnt;
        bad_par = 1'b1;
        send_frame(8'h07, 1'b1, -1);
        repeat (4) @(negedge clk);
        check("par_bad_perr",     32'(perr_cnt - p0),  32'd1);
        check("par_bad_no_ready", 32'(ready_cnt - r0), 32'd0);
        check("par_bad_data",     32'(rx_data), 32'h00);
        check("par_bad_latency",  32'(perr_cyc - busy_rise_cyc), 32'(LAT));
        bad_par = 1'b0;
        send_frame(8'h07, 1'b1, -1);
        repeat (4) @(negedge clk);
        check("par_good_ready", 32'(ready_cnt - r0), 32'd1);
        check("par_good_data",  32'(rx_data), 32'h07);
        check("par_good_no_perr", 32'(perr_cnt - p0), 32'd1);
`else
        p0 = perr_cnt;
        check("no_parity_pulses", 32'(perr_cnt - p0), 32'd0);
`endif

        check("never_ready_and_ferr", 32'(both_seen),   32'h0);
        check("never_ready_twice",    32'(double_seen), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
